// File: rtl/sparse_mxv_pkg.sv
// Shared types and helpers for the sparse matrix-vector row engine.
package sparse_mxv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Cycles spent flushing the three datapath stages after the last beat.
    localparam int DRAIN_CYCLES = 3;

    // Clamp a signed value (up to 64 bits) into the signed range of width ow.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/sparse_mxv_lane.sv
// One nonzero lane: gathers x[idx], multiplies by the weight (registered),
// and presents the product arithmetically shifted right by FRAC.
module sparse_mxv_lane
    import sparse_mxv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int XW   = 12,
    parameter int WW   = 8,
    parameter int FRAC = 7,
    parameter int IDXW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [XLEN*XW-1:0]   x_vec,
    input  logic [WW-1:0]        w,
    input  logic [IDXW-1:0]      idx,
    input  logic                 mask,
    output logic [WW+XW-1:0]     q
);
    localparam int PW = WW + XW;

    logic                 in_range;
    logic signed [XW-1:0] xl;
    logic signed [PW-1:0] p_next;
    logic signed [PW-1:0] p_q;

    // Out-of-range indices only exist when XLEN is not a power of two.
    always_comb begin
        in_range = (32'(idx) < XLEN);
        xl       = in_range ? x_vec[idx*XW +: XW] : '0;
        p_next   = (mask && in_range) ? PW'($signed(w)) * PW'(xl) : '0;
    end

    // NOTE: registers are written with non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
        end else if (en) begin
            p_q <= p_next;
        end
    end

    assign q = p_q >>> FRAC;

endmodule

// File: rtl/sparse_mxv_engine.sv
// Sparse MxV row engine: streams LANES (weight, index) pairs per beat against a
// latched dense x vector through a 3-stage pipeline into a saturated row result.
module sparse_mxv_engine
    import sparse_mxv_pkg::*;
#(
    parameter int  LANES = 4,
    parameter int  XLEN  = 32,
    parameter int  XW    = 12,
    parameter int  WW    = 8,
    parameter int  FRAC  = 7,
    parameter int  OW    = 16,
    parameter int  CNTW  = 14,
    localparam int IDXW  = $clog2(XLEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [XLEN*XW-1:0]      x_vec,
    input  logic [CNTW-1:0]         nnz_beats,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [LANES*WW-1:0]     w_data,
    input  logic [LANES*IDXW-1:0]   w_idx,
    input  logic [LANES-1:0]        w_mask,
    output logic                    y_valid,
    output logic [OW-1:0]           y_data,
    output logic                    busy
);
    localparam int PW = WW + XW;
    localparam int SW = PW + $clog2(LANES);
    localparam int AW = SW + CNTW;

    state_t                 state;
    state_t                 state_next;
    logic [XLEN*XW-1:0]     x_lat;
    logic [CNTW-1:0]        nnz_lat;
    logic [CNTW-1:0]        beat_cnt;
    logic [1:0]             drain_cnt;
    logic                   accept;
    logic                   last_beat;
    logic                   row_start;
    logic [PW-1:0]          q [LANES];
    logic signed [SW-1:0]   lane_sum;
    logic signed [SW-1:0]   s2_sum;
    logic                   s1_valid;
    logic                   s2_valid;
    logic signed [AW-1:0]   acc;

    assign row_start = (state == ST_IDLE) && start;
    assign accept    = w_valid && (state == ST_STREAM);
    assign last_beat = (beat_cnt == nnz_lat - CNTW'(1));

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        w_ready    = 1'b0;
        y_valid    = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (nnz_beats != '0) ? ST_STREAM : ST_DRAIN;
                end
            end
            ST_STREAM: begin
                w_ready = 1'b1;
                if (accept && last_beat) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                y_valid    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            x_lat     <= '0;
            nnz_lat   <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (row_start) begin
                x_lat    <= x_vec;
                nnz_lat  <= nnz_beats;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + CNTW'(1);
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sparse_mxv_lane #(
            .XLEN (XLEN),
            .XW   (XW),
            .WW   (WW),
            .FRAC (FRAC),
            .IDXW (IDXW)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en    (accept),
            .x_vec (x_lat),
            .w     (w_data[l*WW +: WW]),
            .idx   (w_idx[l*IDXW +: IDXW]),
            .mask  (w_mask[l]),
            .q     (q[l])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + SW'($signed(q[l]));
        end
    end

    // Beat-valid bit travels alongside the data so bubbles never touch acc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            acc      <= '0;
            y_data   <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum <= lane_sum;
            end
            if (row_start) begin
                acc <= '0;
            end else if (s2_valid) begin
                acc <= acc + AW'(s2_sum);
            end
            if (state == ST_DRAIN && state_next == ST_DONE) begin
                y_data <= OW'(sat_signed(64'(acc), OW));
            end
        end
    end

endmodule

// File: tb/tb_sparse_mxv_engine.sv
// Scoreboard bench for sparse_mxv_engine: directed rows push expected results,
// an independent monitor checks y_data and latency whenever y_valid is seen.
module tb_sparse_mxv_engine;
    localparam int LANES = 4;
    localparam int XLEN  = 32;
    localparam int XW    = 12;
    localparam int WW    = 8;
    localparam int OW    = 16;
    localparam int CNTW  = 14;
    localparam int IDXW  = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [XLEN*XW-1:0]    x_vec;
    logic [CNTW-1:0]       nnz_beats;
    logic                  w_valid;
    logic                  w_ready;
    logic [LANES*WW-1:0]   w_data;
    logic [LANES*IDXW-1:0] w_idx;
    logic [LANES-1:0]      w_mask;
    logic                  y_valid;
    logic [OW-1:0]         y_data;
    logic                  busy;

    sparse_mxv_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_vec     (x_vec),
        .nnz_beats (nnz_beats),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_mask    (w_mask),
        .y_valid   (y_valid),
        .y_data    (y_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint y;
        int     ref_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Beat used by several rows: w={1,2,3,4}, idx={0,5,9,31} for lanes 0..3.
    localparam logic [31:0] W1   = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [19:0] IDX1 = {5'd31, 5'd9, 5'd5, 5'd0};
    localparam logic [19:0] IDX0 = {5'd3, 5'd2, 5'd1, 5'd0};

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic set_pattern1();
        x_vec = '0;
        x_vec[0*XW +: XW]  = 12'd128;
        x_vec[5*XW +: XW]  = 12'd256;
        x_vec[9*XW +: XW]  = 12'hF80;
        x_vec[31*XW +: XW] = 12'd64;
    endtask

    // Called at a negedge with the engine idle; returns the start-edge cycle stamp.
    task automatic do_start(input int nnz, output int st_cyc);
        start     = 1'b1;
        nnz_beats = CNTW'(nnz);
        @(negedge clk);
        start  = 1'b0;
        st_cyc = cyc;
    endtask

    // Holds the beat until accepted (bounded) and returns the accepting-edge stamp.
    task automatic send_beat(input logic [31:0] w, input logic [19:0] idx,
                             input logic [3:0] m, output int acc_cyc);
        int n;
        n       = 0;
        w_valid = 1'b1;
        w_data  = w;
        w_idx   = idx;
        w_mask  = m;
        while (!w_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("beat_accepted", w_ready, 1);
        @(negedge clk);
        acc_cyc = cyc;
        w_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("row_completes", busy, 0);
    endtask

    // Monitor: compare every presented result against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && y_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_y_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("y_data", longint'($signed(y_data)), e.y);
                    check("y_latency_cycle", cyc - e.ref_cyc + 1, 4);
                end
            end
        end
    end

    initial begin
        int sc;
        int a;
        bit seen_ready;
        int n;

        rst       = 1'b1;
        start     = 1'b0;
        x_vec     = '0;
        nnz_beats = '0;
        w_valid   = 1'b0;
        w_data    = '0;
        w_idx     = '0;
        w_mask    = '0;
        repeat (2) @(negedge clk);
        check("reset_w_ready", w_ready, 0);
        check("reset_y_valid", y_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_y_data", y_data, 0);
        rst = 1'b0;
        set_pattern1();
        @(negedge clk);

        // Reset in the middle of a row aborts it without a result.
        do_start(3, sc);
        check("busy_after_start", busy, 1);
        send_beat(W1, IDX1, 4'hF, a);
        #2 rst = 1'b1;
        #1;
        check("midrow_reset_w_ready", w_ready, 0);
        check("midrow_reset_busy", busy, 0);
        check("midrow_reset_y_valid", y_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Single beat: 1 + 4 - 3 + 2 = 4.
        do_start(1, sc);
        send_beat(W1, IDX1, 4'hF, a);
        exp_q.push_back('{4, a});
        check("ready_drop_single", w_ready, 0);
        wait_idle();
        @(negedge clk);
        check("y_data_hold", longint'($signed(y_data)), 4);

        // Three beats with 2-cycle bubbles, last beat masked to lanes 0,1: 4+4+5 = 13.
        do_start(3, sc);
        send_beat(W1, IDX1, 4'hF, a);
        repeat (2) begin
            check("ready_in_bubble", w_ready, 1);
            @(negedge clk);
        end
        send_beat(W1, IDX1, 4'hF, a);
        repeat (2) begin
            check("ready_in_bubble", w_ready, 1);
            @(negedge clk);
        end
        send_beat(W1, IDX1, 4'b0011, a);
        exp_q.push_back('{13, a});
        check("ready_drop_multi", w_ready, 0);
        wait_idle();

        // Positive saturation: 5 * 4 * 2031 = 40620 -> 32767.
        x_vec = {XLEN{12'd2047}};
        do_start(5, sc);
        for (int b = 0; b < 5; b++) send_beat({4{8'd127}}, IDX0, 4'hF, a);
        exp_q.push_back('{32767, a});
        wait_idle();

        // Negative saturation: 5 * 4 * -2047 = -40940 -> -32768.
        do_start(5, sc);
        for (int b = 0; b < 5; b++) send_beat({4{8'h80}}, IDX0, 4'hF, a);
        exp_q.push_back('{-32768, a});
        wait_idle();

        // Zero-beat row: no w_ready, result 0 in the 4th cycle after start.
        do_start(0, sc);
        exp_q.push_back('{0, sc});
        seen_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (w_ready) seen_ready = 1'b1;
            @(negedge clk);
        end
        check("ready_zero_row", seen_ready, 0);
        check("zero_row_idle", busy, 0);

        // Start pulse during STREAM must not relatch nnz_beats or x_vec: 4+4 = 8.
        set_pattern1();
        do_start(2, sc);
        send_beat(W1, IDX1, 4'hF, a);
        start     = 1'b1;
        nnz_beats = CNTW'(1);
        x_vec     = '0;
        @(negedge clk);
        start = 1'b0;
        check("busy_kept", busy, 1);
        check("ready_kept", w_ready, 1);
        send_beat(W1, IDX1, 4'hF, a);
        exp_q.push_back('{8, a});
        wait_idle();

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
